// File: rtl/display_scroll_ctrl_pkg.sv
// Shared board geometry, digit/row types and scroll FSM encoding for the
// display scroll controller.
package display_pkg;

    localparam int           ROW_PITCH      = 150;
    localparam int           DIGITS_PER_ROW = 6;
    localparam int           NUM_ROWS       = 4;
    localparam logic [3:0]   BLANK_DIGIT    = 4'hF;

    typedef logic [3:0]                    digit_t;
    typedef logic [DIGITS_PER_ROW*4-1:0]   row_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        SHIFT  = 2'd2
    } scroll_state_t;

    function automatic row_t blank_row(input digit_t d);
        return {DIGITS_PER_ROW{d}};
    endfunction

endpackage

// File: rtl/display_scroll_ctrl_step_counter.sv
// Saturating displacement counter: advances by STEP on each step pulse while
// enabled, clamps at MAX_VAL, and returns to zero on clear.
module scroll_step_counter
    import display_pkg::*;
#(
    parameter int MAX_VAL = 150,
    parameter int STEP    = 10
) (
    input  logic        i_clk,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_step,
    output logic [10:0] o_value,
    output logic        o_at_max
);

    logic [11:0] sum;

    // 12-bit sum so the clamp compare never sees a wrapped value
    assign sum      = {1'b0, o_value} + 12'(STEP);
    assign o_at_max = (o_value == 11'(MAX_VAL));

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            o_value <= '0;
        end else if (i_enable && i_step) begin
            if (sum > 12'(MAX_VAL))
                o_value <= 11'(MAX_VAL);
            else
                o_value <= sum[10:0];
        end
    end

endmodule

// File: rtl/display_scroll_ctrl.sv
// Board image owner: accepts committed rows, scrolls them up one row pitch
// frame by frame, then shifts the board contents up by one row.
module display_scroll_ctrl #(
    parameter int         ROW_PITCH   = 150,
    parameter int         STEP        = 10,
    parameter logic [3:0] BLANK_DIGIT = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_start,
    input  logic        i_commit_valid,
    output logic        o_commit_ready,
    input  logic [23:0] i_commit_digits,
    input  logic        i_commit_correct,
    input  logic [23:0] i_preview_digits,
    input  logic        i_clear,
    output logic [95:0] o_digit_showed,
    output logic [1:0]  o_correctness,
    output logic [10:0] o_displacement,
    output logic        o_busy
);

    display_pkg::scroll_state_t state;
    display_pkg::row_t          board [display_pkg::NUM_ROWS];

    logic clear_pend;
    logic idle;
    logic do_clear;
    logic accept;
    logic at_max;

    assign idle           = (state == display_pkg::IDLE);
    assign do_clear       = idle & (i_clear | clear_pend);
    // A clear (fresh or deferred) owns the IDLE cycle, so no commit then
    assign o_commit_ready = idle & ~i_clear & ~clear_pend;
    assign accept         = i_commit_valid & o_commit_ready;

    assign o_digit_showed = {board[0], board[1], board[2], board[3]};

    // Counter sits at zero outside SCROLL, so the SHIFT edge zeroes it
    // together with the row move.
    scroll_step_counter #(
        .MAX_VAL (ROW_PITCH),
        .STEP    (STEP)
    ) u_step (
        .i_clk    (i_clk),
        .i_clear  (i_rst | (state != display_pkg::SCROLL)),
        .i_enable (state == display_pkg::SCROLL),
        .i_step   (i_frame_start),
        .o_value  (o_displacement),
        .o_at_max (at_max)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < display_pkg::NUM_ROWS; r++)
                board[r] <= display_pkg::blank_row(BLANK_DIGIT);
            o_correctness <= 2'b00;
            o_busy        <= 1'b0;
            clear_pend    <= 1'b0;
            state         <= display_pkg::IDLE;
        end else begin
            case (state)
                display_pkg::IDLE: begin
                    if (do_clear) begin
                        for (int r = 0; r < display_pkg::NUM_ROWS; r++)
                            board[r] <= display_pkg::blank_row(BLANK_DIGIT);
                        o_correctness <= 2'b00;
                        clear_pend    <= 1'b0;
                    end else if (accept) begin
                        board[1]         <= i_commit_digits;
                        o_correctness[1] <= i_commit_correct;
                        o_busy           <= 1'b1;
                        state            <= display_pkg::SCROLL;
                    end
                end
                display_pkg::SCROLL: begin
                    clear_pend <= clear_pend | i_clear;
                    if (i_frame_start && at_max)
                        state <= display_pkg::SHIFT;
                end
                display_pkg::SHIFT: begin
                    board[0]      <= board[1];
                    board[1]      <= board[2];
                    board[2]      <= board[3];
                    board[3]      <= i_preview_digits;
                    o_correctness <= {1'b0, o_correctness[1]};
                    clear_pend    <= clear_pend | i_clear;
                    o_busy        <= 1'b0;
                    state         <= display_pkg::IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= display_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Drives two controllers (STEP=10 and STEP=40) with shared stimulus and checks
// both against a frame-count reference model of the scroll behaviour.
module tb_display_scroll_ctrl;

    localparam int PITCH = 150;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, frame, valid, correct, clear;
    logic [23:0] digits, preview;

    logic [1:0][95:0] dig;
    logic [1:0][1:0]  cor;
    logic [1:0][10:0] dsp;
    logic [1:0]       bsy, rdy;

    display_scroll_ctrl #(.ROW_PITCH(PITCH), .STEP(10), .BLANK_DIGIT(4'hF)) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame),
        .i_commit_valid(valid), .o_commit_ready(rdy[0]),
        .i_commit_digits(digits), .i_commit_correct(correct),
        .i_preview_digits(preview), .i_clear(clear),
        .o_digit_showed(dig[0]), .o_correctness(cor[0]),
        .o_displacement(dsp[0]), .o_busy(bsy[0]));

    display_scroll_ctrl #(.ROW_PITCH(PITCH), .STEP(40), .BLANK_DIGIT(4'hF)) dut40 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(frame),
        .i_commit_valid(valid), .o_commit_ready(rdy[1]),
        .i_commit_digits(digits), .i_commit_correct(correct),
        .i_preview_digits(preview), .i_clear(clear),
        .o_digit_showed(dig[1]), .o_correctness(cor[1]),
        .o_displacement(dsp[1]), .o_busy(bsy[1]));

    // Reference model: a scroll is "frames counted since acceptance";
    // displacement = min(frames*step, pitch); the pulse after reaching the
    // pitch arms the row shift, which happens on the following edge.
    int          step_of [2] = '{10, 40};
    logic [23:0] m_rows  [2][4];
    logic [1:0]  m_corr  [2];
    bit          m_busy  [2];
    bit          m_shift [2];
    bit          m_cpend [2];
    int          m_nfr   [2];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int frames_to_top(int i);
        return (PITCH + step_of[i] - 1) / step_of[i];
    endfunction

    function automatic int exp_disp(int i);
        int d;
        if (!m_busy[i]) return 0;
        d = m_nfr[i] * step_of[i];
        return (d > PITCH) ? PITCH : d;
    endfunction

    task automatic model_blank(int i);
        for (int r = 0; r < 4; r++) m_rows[i][r] = 24'hFFFFFF;
        m_corr[i] = 2'b00;
    endtask

    task automatic model_edge(int i);
        if (rst) begin
            model_blank(i);
            m_busy[i] = 0; m_shift[i] = 0; m_cpend[i] = 0; m_nfr[i] = 0;
        end else if (!m_busy[i]) begin
            if (clear || m_cpend[i]) begin
                model_blank(i);
                m_cpend[i] = 0;
            end else if (valid) begin
                m_rows[i][1] = digits;
                m_corr[i][1] = correct;
                m_busy[i] = 1; m_nfr[i] = 0; m_shift[i] = 0;
            end
        end else begin
            if (clear) m_cpend[i] = 1;
            if (m_shift[i]) begin
                m_rows[i][0] = m_rows[i][1];
                m_rows[i][1] = m_rows[i][2];
                m_rows[i][2] = m_rows[i][3];
                m_rows[i][3] = preview;
                m_corr[i] = {1'b0, m_corr[i][1]};
                m_busy[i] = 0; m_shift[i] = 0; m_nfr[i] = 0;
            end else if (frame) begin
                if (m_nfr[i] >= frames_to_top(i)) m_shift[i] = 1;
                else m_nfr[i]++;
            end
        end
    endtask

    task automatic chk(string tag, int i, logic [95:0] got, logic [95:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, i, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("board", i, dig[i],
                {m_rows[i][0], m_rows[i][1], m_rows[i][2], m_rows[i][3]});
            chk("correctness", i, 96'(cor[i]), 96'(m_corr[i]));
            chk("displacement", i, 96'(dsp[i]), 96'(exp_disp(i)));
            chk("busy", i, 96'(bsy[i]), 96'(m_busy[i]));
            chk("ready", i, 96'(rdy[i]),
                96'(!m_busy[i] && !clear && !m_cpend[i]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        cyc();
        frame = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0; valid = 1'b0; correct = 1'b0; clear = 1'b0;
        digits = '0; preview = '0;
        for (int i = 0; i < 2; i++) begin
            model_blank(i);
            m_busy[i] = 0; m_shift[i] = 0; m_cpend[i] = 0; m_nfr[i] = 0;
        end

        // Reset state
        cyc();
        rst = 1'b0;
        cyc();
        chk("reset_blank", 0, dig[0], {96{1'b1}});

        // Commit 123456 (coincident frame ignored), full scroll, shift in 789012
        digits = 24'h123456; correct = 1'b1; valid = 1'b1; preview = 24'h789012;
        frame = 1'b1;
        cyc();
        valid = 1'b0; frame = 1'b0;
        chk("disp_after_accept", 0, 96'(dsp[0]), 96'(0));
        for (int k = 0; k < 16; k++) pulse_frame();
        cyc();
        chk("row0_after_shift", 0, 96'(dig[0][95:72]), 96'(24'h123456));
        chk("corr_after_shift", 0, 96'(cor[0]), 96'(2'b01));
        chk("preview_row3", 0, 96'(dig[0][23:0]), 96'(24'h789012));

        // Commit held valid through scrolling: one row per acceptance
        valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            digits = 24'($urandom); correct = 1'($urandom); preview = 24'($urandom);
            pulse_frame();
        end
        valid = 1'b0;
        for (int k = 0; k < 20; k++) pulse_frame();

        // Reset in the middle of a scroll (STEP=10 instance at 60)
        digits = 24'hABCDEF; valid = 1'b1;
        cyc();
        valid = 1'b0;
        for (int k = 0; k < 6; k++) pulse_frame();
        chk("disp_before_rst", 0, 96'(dsp[0]), 96'(60));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("disp_after_rst", 0, 96'(dsp[0]), 96'(0));

        // Clear at displacement 90 is deferred until after the shift
        digits = 24'h246801; correct = 1'b1; valid = 1'b1;
        cyc();
        valid = 1'b0;
        for (int k = 0; k < 9; k++) pulse_frame();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int k = 0; k < 10; k++) pulse_frame();
        cyc();
        chk("blank_after_deferred_clear", 0, dig[0], {96{1'b1}});

        // Clear and commit in the same IDLE cycle: clear wins
        digits = 24'h135790; valid = 1'b1; clear = 1'b1;
        cyc();
        valid = 1'b0; clear = 1'b0;
        chk("commit_blocked_by_clear", 0, 96'(bsy[0]), 96'(0));

        // Randomised traffic
        for (int k = 0; k < 500; k++) begin
            frame   = ($urandom_range(0, 2) == 0);
            valid   = 1'($urandom);
            digits  = 24'($urandom);
            correct = 1'($urandom);
            preview = 24'($urandom);
            clear   = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; frame = 1'b0; valid = 1'b0; clear = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
